quadrature_decoder: RTL

//  Decodes one incremental encoder (A/B quadrature) into a signed position count, one instance per axis (yaw, pitch).

---
 rtl/quadrature_decoder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/quadrature_decoder.sv
// Quadrature (A/B) encoder decoder: synchronise, deglitch and x4-count one axis into a signed
// wrapping position, with sticky illegal-transition flag and soft zero.
module quadrature_decoder #(
    parameter int unsigned QD_DATA_WIDTH = 16,
    parameter int unsigned FILTER_LEN    = 3
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     QD_A,
    input  logic                     QD_B,
    input  logic                     ZERO,
    output logic [QD_DATA_WIDTH-1:0] COUNT,
    output logic                     DIR,
    output logic                     ERROR
);

    localparam int unsigned FiltW   = $clog2(FILTER_LEN + 1);
    localparam int unsigned InitLen = 2 + FILTER_LEN;
    localparam int unsigned InitW   = $clog2(InitLen + 1);

    localparam logic [FiltW-1:0]         FiltMax  = FiltW'(FILTER_LEN - 1);
    localparam logic [FiltW-1:0]         FiltOne  = FiltW'(1);
    localparam logic [InitW-1:0]         InitMax  = InitW'(InitLen - 1);
    localparam logic [InitW-1:0]         InitOne  = InitW'(1);
    localparam logic [QD_DATA_WIDTH-1:0] CountOne = QD_DATA_WIDTH'(1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    // Channel vectors are packed as {A, B}: bit 1 = A, bit 0 = B.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            filt_q, filt_d;
    logic [1:0]            prev_q, prev_d;
    logic [1:0][FiltW-1:0] fcnt_q, fcnt_d;
    state_e                state_q, state_d;
    logic [InitW-1:0]      init_cnt_q, init_cnt_d;
    logic [QD_DATA_WIDTH-1:0] count_q, count_d;
    logic                  dir_q, dir_d;
    logic                  error_q, error_d;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        filt_d     = filt_q;
        fcnt_d     = fcnt_q;
        prev_d     = prev_q;
        count_d    = count_q;
        dir_d      = dir_q;
        error_d    = error_q;

        unique case (state_q)
            StInit: begin
                // Track the pins directly so RUN starts with no phantom step.
                filt_d = sync2_q;
                prev_d = sync2_q;
                fcnt_d = '0;
                if (init_cnt_q == InitMax) begin
                    state_d = StRun;
                end else begin
                    init_cnt_d = init_cnt_q + InitOne;
                end
            end
            StRun: begin
                prev_d = filt_q;
                for (int i = 0; i < 2; i++) begin
                    if (sync2_q[i] == filt_q[i]) begin
                        fcnt_d[i] = '0;
                    end else if (fcnt_q[i] == FiltMax) begin
                        filt_d[i] = sync2_q[i];
                        fcnt_d[i] = '0;
                    end else begin
                        fcnt_d[i] = fcnt_q[i] + FiltOne;
                    end
                end

                case ({prev_q, filt_q})
                    4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                        count_d = count_q + CountOne;
                        dir_d   = 1'b1;
                    end
                    4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                        count_d = count_q - CountOne;
                        dir_d   = 1'b0;
                    end
                    4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: begin
                        error_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        endcase

        // Soft zero overrides any step or error landing on the same edge.
        if (ZERO) begin
            count_d = '0;
            error_d = 1'b0;
            dir_d   = dir_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            fcnt_q     <= '0;
            state_q    <= StInit;
            init_cnt_q <= '0;
            count_q    <= '0;
            dir_q      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            sync1_q    <= {QD_A, QD_B};
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            error_q    <= error_d;
        end
    end

    assign COUNT = count_q;
    assign DIR   = dir_q;
    assign ERROR = error_q;

endmodule
